// File: rtl/uart_operand_pkg.sv
// Shared types and constants for the UART operand receive stage.
package uart_operand_pkg;

  localparam int OP_WIDTH   = 16;
  localparam int BYTE_WIDTH = 8;
  // Width of the bit-period counter; holds the largest default divisor.
  localparam int DIV_WIDTH  = 16;

  localparam int DEF_BIT_DIV_0    = 5208;
  localparam int DEF_BIT_DIV_1    = 2604;
  localparam int DEF_BIT_DIV_2    = 868;
  localparam int DEF_BIT_DIV_3    = 434;
  localparam int DEF_PAIR_TIMEOUT = 1_000_000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: loaded with DIV/2 or DIV, pulses tick once on expiry.
module uart_bit_timer
  import uart_operand_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 load_half,
  input  logic                 load_full,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt;
  logic                 armed;

  // Tick fires in the cycle the count reaches zero; the FSM acts on the next edge,
  // which lands exactly N edges after the load.
  assign tick = armed & (cnt == '0);

  // Count down after a load; disarm after one tick so it never repeats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (load_half) begin
      cnt   <= (divisor >> 1) - DIV_WIDTH'(1);
      armed <= 1'b1;
    end else if (load_full) begin
      cnt   <= divisor - DIV_WIDTH'(1);
      armed <= 1'b1;
    end else if (tick) begin
      armed <= 1'b0;
    end else if (armed) begin
      cnt <= cnt - DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_operand_rx.sv
// 8N1 UART receiver that packs byte pairs into {B, A} operand words.
// Handshake: op_valid/op_data are held stable until a clock edge where
// op_valid & op_ready are both 1; the word is consumed on that edge and
// op_valid drops afterwards unless a new word completes on the same edge.
module uart_operand_rx
  import uart_operand_pkg::*;
#(
  parameter int BIT_DIV_0    = DEF_BIT_DIV_0,
  parameter int BIT_DIV_1    = DEF_BIT_DIV_1,
  parameter int BIT_DIV_2    = DEF_BIT_DIV_2,
  parameter int BIT_DIV_3    = DEF_BIT_DIV_3,
  parameter int PAIR_TIMEOUT = DEF_PAIR_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            freq_control,
  input  logic                  uart_rx,
  input  logic                  op_ready,
  output logic                  op_valid,
  output logic [OP_WIDTH-1:0]   op_data,
  output logic                  byte_valid,
  output logic [BYTE_WIDTH-1:0] byte_data,
  output logic                  frame_err,
  output logic                  overrun,
  output rx_state_t             rx_state
);

  localparam int TW = $clog2(PAIR_TIMEOUT + 1);
  localparam logic [TW-1:0] TOUT_LAST = TW'(PAIR_TIMEOUT - 1);

  rx_state_t             state, state_next;
  logic [2:0]            bit_idx, bit_next;
  logic [BYTE_WIDTH-1:0] shreg, a_q;
  logic [DIV_WIDTH-1:0]  div_sel, div_q, timer_div;
  logic                  rx_meta, rx_s, rx_prev, rx_fall;
  logic                  tick, load_half, load_full, shift_en, latch_div;
  logic                  byte_good, frame_bad, half, accept;
  logic [TW-1:0]         tout_cnt;

  assign rx_state = state;
  assign rx_fall  = rx_prev & ~rx_s;
  assign accept   = op_valid & op_ready;
  // The divisor is latched on the start edge, so the timer sees the fresh
  // selection on that one cycle and the held copy for the rest of the frame.
  assign timer_div = latch_div ? div_sel : div_q;

  // Baud divisor selected by freq_control.
  always_comb begin
    case (freq_control)
      2'd0:    div_sel = DIV_WIDTH'(BIT_DIV_0);
      2'd1:    div_sel = DIV_WIDTH'(BIT_DIV_1);
      2'd2:    div_sel = DIV_WIDTH'(BIT_DIV_2);
      default: div_sel = DIV_WIDTH'(BIT_DIV_3);
    endcase
  end

  // Two-flop synchroniser plus one delay flop for falling-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  uart_bit_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .divisor   (timer_div),
    .load_half (load_half),
    .load_full (load_full),
    .tick      (tick)
  );

  // Receive FSM next-state and control decode.
  always_comb begin
    state_next = state;
    bit_next   = bit_idx;
    load_half  = 1'b0;
    load_full  = 1'b0;
    shift_en   = 1'b0;
    latch_div  = 1'b0;
    byte_good  = 1'b0;
    frame_bad  = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (rx_fall) begin
          state_next = START;
          load_half  = 1'b1;
          latch_div  = 1'b1;
        end
        START: if (tick) begin
          if (!rx_s) begin
            state_next = DATA;
            load_full  = 1'b1;
            bit_next   = 3'd0;
          end else begin
            state_next = IDLE;
          end
        end
        DATA: if (tick) begin
          shift_en  = 1'b1;
          load_full = 1'b1;
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_next   = bit_idx + 3'd1;
        end
        STOP: if (tick) begin
          if (rx_s) begin
            byte_good  = 1'b1;
            state_next = IDLE;
          end else begin
            frame_bad  = 1'b1;
            state_next = BREAK;
          end
        end
        BREAK: if (rx_s) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM state, bit index, shift register and latched divisor.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bit_idx <= 3'd0;
      shreg   <= '0;
      div_q   <= '0;
    end else begin
      state   <= state_next;
      bit_idx <= bit_next;
      if (shift_en)  shreg <= {rx_s, shreg[BYTE_WIDTH-1:1]};
      if (latch_div) div_q <= div_sel;
    end
  end

  // Per-byte status pulses and last good byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= byte_good;
      frame_err  <= frame_bad;
      if (byte_good) byte_data <= shreg;
    end
  end

  // Pair assembly, output handshake, overrun flag and stale-half timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_valid <= 1'b0;
      op_data  <= '0;
      overrun  <= 1'b0;
      half     <= 1'b0;
      a_q      <= '0;
      tout_cnt <= '0;
    end else if (!enable) begin
      op_valid <= 1'b0;
      overrun  <= 1'b0;
      half     <= 1'b0;
    end else begin
      if (accept) op_valid <= 1'b0;
      if (byte_good && !half) begin
        a_q      <= shreg;
        half     <= 1'b1;
        tout_cnt <= '0;
      end else if (byte_good) begin
        if (op_valid && !accept) begin
          overrun <= 1'b1;
        end else begin
          op_data  <= {shreg, a_q};
          op_valid <= 1'b1;
          half     <= 1'b0;
        end
      end else if (half && state == IDLE) begin
        if (tout_cnt == TOUT_LAST) half <= 1'b0;
        else                       tout_cnt <= tout_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_operand_rx.sv
// Self-checking bench for uart_operand_rx: directed scenarios plus a random phase.
module tb_uart_operand_rx;
  import uart_operand_pkg::*;

  localparam int DIV0 = 16, DIV1 = 12, DIV2 = 10, DIV3 = 8;
  localparam int TOUT = 400;

  logic        clk, reset, enable, uart_rx, op_ready;
  logic [1:0]  freq_control;
  logic        op_valid, byte_valid, frame_err, overrun;
  logic [15:0] op_data;
  logic [7:0]  byte_data;
  rx_state_t   rx_state;

  uart_operand_rx #(
    .BIT_DIV_0(DIV0), .BIT_DIV_1(DIV1), .BIT_DIV_2(DIV2), .BIT_DIV_3(DIV3),
    .PAIR_TIMEOUT(TOUT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .freq_control(freq_control),
    .uart_rx(uart_rx), .op_ready(op_ready), .op_valid(op_valid), .op_data(op_data),
    .byte_valid(byte_valid), .byte_data(byte_data), .frame_err(frame_err),
    .overrun(overrun), .rx_state(rx_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, got timeout, required finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int bytes_seen = 0;
  int fe_seen = 0;

  always @(negedge clk) begin
    if (reset && byte_valid) begin
      bytes_seen++;
      if (exp_q.size() == 0) check("byte_spurious", 32'(byte_data), 32'h100);
      else                   check("byte_data", 32'(byte_data), 32'(exp_q.pop_front()));
    end
    if (reset && frame_err) fe_seen++;
  end

  // Pair-level reference: what the consumer should see after each byte.
  logic        m_half, m_valid, m_overrun;
  logic [7:0]  m_a;
  logic [15:0] m_data;

  task automatic model_clear_all();
    m_half = 0; m_valid = 0; m_overrun = 0; m_a = 0; m_data = 0;
  endtask

  task automatic model_good_byte(input logic [7:0] b);
    if (!m_half) begin
      m_a = b; m_half = 1;
    end else if (m_valid) begin
      m_overrun = 1;
    end else begin
      m_data = {b, m_a}; m_valid = 1; m_half = 0;
    end
  endtask

  task automatic check_pair(input string tag);
    check({tag, "_valid"}, 32'(op_valid), 32'(m_valid));
    check({tag, "_data"}, 32'(op_data), 32'(m_data));
    check({tag, "_overrun"}, 32'(overrun), 32'(m_overrun));
  endtask

  // ---------------- drivers ----------------
  function automatic int div_of(input logic [1:0] fc);
    case (fc)
      2'd0: return DIV0;
      2'd1: return DIV1;
      2'd2: return DIV2;
      default: return DIV3;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame at bclk clocks per bit, then a short idle so outputs settle.
  task automatic send_frame(input logic [7:0] b, input int bclk, input logic stop_bit);
    @(negedge clk);
    uart_rx = 1'b0;
    idle(bclk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(bclk);
    end
    uart_rx = stop_bit;
    idle(bclk);
    uart_rx = 1'b1;
    idle(6);
  endtask

  task automatic send_good(input logic [7:0] b, input int bclk);
    exp_q.push_back(b);
    send_frame(b, bclk, 1'b1);
    model_good_byte(b);
  endtask

  task automatic accept_word();
    @(negedge clk);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    m_valid = 0;
  endtask

  task automatic pulse_disable();
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    m_half = 0; m_valid = 0; m_overrun = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    bit held_ok;
    reset = 1'b0; enable = 1'b1; uart_rx = 1'b1; op_ready = 1'b0; freq_control = 2'd0;
    model_clear_all();
    idle(3);
    check("rst_op_valid", 32'(op_valid), 0);
    check("rst_op_data", 32'(op_data), 0);
    check("rst_byte_valid", 32'(byte_valid), 0);
    check("rst_byte_data", 32'(byte_data), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_state", 32'(rx_state), 32'(IDLE));
    reset = 1'b1;
    idle(4);

    // 1: simple pair, held without ready, then accepted
    base = bytes_seen;
    send_good(8'h05, DIV0);
    check("s1_after_a_valid", 32'(op_valid), 0);
    send_good(8'h07, DIV0);
    check("s1_bytes", 32'(bytes_seen - base), 2);
    check_pair("s1");
    check("s1_word", 32'(op_data), 32'h0705);
    held_ok = 1;
    repeat (50) begin
      @(negedge clk);
      if (op_valid !== 1'b1 || op_data !== 16'h0705) held_ok = 0;
    end
    check("s1_held", 32'(held_ok), 1);
    accept_word();
    check("s1_dropped", 32'(op_valid), 0);

    // 2: third byte becomes next A, fourth overruns
    send_good(8'h12, DIV0);
    send_good(8'h34, DIV0);
    send_good(8'h56, DIV0);
    check_pair("s2a");
    check("s2_word", 32'(op_data), 32'h3412);
    send_good(8'h78, DIV0);
    check_pair("s2b");
    check("s2_overrun_set", 32'(overrun), 1);
    pulse_disable();
    check_pair("s2_disable");

    // 3: framing error, then a clean pair
    base = bytes_seen;
    fe_seen = 0;
    send_frame(8'hA5, DIV0, 1'b0);
    idle(4);
    check("s3_frame_err", 32'(fe_seen), 1);
    check("s3_no_byte", 32'(bytes_seen - base), 0);
    check("s3_no_valid", 32'(op_valid), 0);
    send_good(8'h01, DIV0);
    send_good(8'h02, DIV0);
    check_pair("s3");
    accept_word();

    // 4: short glitch is ignored; stale half-pair times out
    base = bytes_seen;
    @(negedge clk);
    uart_rx = 1'b0;
    idle(6);
    uart_rx = 1'b1;
    idle(30);
    check("s4_glitch_nobyte", 32'(bytes_seen - base), 0);
    check("s4_state_idle", 32'(rx_state), 32'(IDLE));
    send_good(8'h11, DIV0);
    idle(500);
    m_half = 0;
    send_good(8'h22, DIV0);
    send_good(8'h33, DIV0);
    check_pair("s4");
    accept_word();

    // 5: fast rate, then a rate change in the middle of a frame
    freq_control = 2'd3;
    send_good(8'hFF, DIV3);
    send_good(8'h00, DIV3);
    check_pair("s5");
    exp_q.push_back(8'hC3);
    fork
      send_frame(8'hC3, DIV3, 1'b1);
      begin idle(30); freq_control = 2'd0; end
    join
    model_good_byte(8'hC3);
    check_pair("s5_switch");

    // 6: asynchronous reset while receiving byte B
    fork
      send_frame(8'h5A, DIV0, 1'b1);
      begin
        idle(DIV0 * 4);
        #2 reset = 1'b0;
        #1;
        check("s6_op_valid", 32'(op_valid), 0);
        check("s6_op_data", 32'(op_data), 0);
        check("s6_byte_data", 32'(byte_data), 0);
        check("s6_byte_valid", 32'(byte_valid), 0);
        check("s6_overrun", 32'(overrun), 0);
        check("s6_frame_err", 32'(frame_err), 0);
        check("s6_state", 32'(rx_state), 32'(IDLE));
      end
    join
    model_clear_all();
    @(negedge clk);
    reset = 1'b1;
    idle(4);
    send_good(8'h09, DIV0);
    send_good(8'h0A, DIV0);
    check_pair("s6");
    check("s6_word", 32'(op_data), 32'h0A09);
    accept_word();

    // random phase: random bytes, rates, gaps and consumer behaviour
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      int gap;
      b = 8'($urandom_range(0, 255));
      freq_control = 2'($urandom_range(0, 3));
      send_good(b, div_of(freq_control));
      check_pair("rnd");
      if (m_valid && $urandom_range(0, 1) == 1) accept_word();
      gap = ($urandom_range(0, 9) == 0) ? 450 : $urandom_range(2, 30);
      idle(gap);
      if (gap >= TOUT) m_half = 0;
      if ($urandom_range(0, 19) == 0) pulse_disable();
    end
    idle(10);
    check("final_queue_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
